// File: rtl/tx_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_burst_pkg
// Brief    : Shared command encodings, channel state type and helper for the
//            transmit burst array.
// Revision : 1.0
// ============================================================================
package tx_burst_pkg;

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_FIRE  = 2'b01;
   localparam logic [1:0] CMD_CLEAR = 2'b10;

   typedef enum logic [2:0] {
      CH_IDLE    = 3'd0,
      CH_WAIT_PD = 3'd1,
      CH_ON      = 3'd2,
      CH_OFF     = 3'd3,
      CH_DONE    = 3'd4
   } chState_t;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_burst_channel.sv
`default_nettype none
// ============================================================================
// Module   : tx_burst_channel
// Brief    : One transducer channel: delay, pulse train, over-on safety trip.
// Revision : 1.0
// ============================================================================
module tx_burst_channel
   import tx_burst_pkg::*;
#(
   parameter int PD_W   = 16,
   parameter int CT_W   = 9,
   parameter int NP_W   = 8,
   parameter int PER_W  = 16,
   parameter int MAX_ON = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             latch,
   input  logic             abort,
   input  logic             clrErr,
   input  logic             busy,
   input  logic [PD_W-1:0]  pdIn,
   input  logic [CT_W-1:0]  ctIn,
   input  logic [NP_W-1:0]  npIn,
   input  logic [PER_W-1:0] perIn,
   input  logic [PER_W-1:0] per,
   output logic             txOut,
   output logic             errOut,
   output logic             doneNext
);

   localparam int CNT_W = maxInt(maxInt(PD_W, PER_W), CT_W) + 1;
   localparam int ON_W  = $clog2(MAX_ON + 1);

   chState_t          r_state, w_stateNxt;
   logic [CNT_W-1:0]  r_phase, w_phaseNxt;
   logic [PD_W-1:0]   r_pd, w_pdNxt;
   logic [CT_W-1:0]   r_ct, w_ctNxt;
   logic [NP_W-1:0]   r_left, w_leftNxt;
   logic              r_tx, w_txNxt;
   logic              r_err;
   logic [ON_W-1:0]   r_onCnt;
   logic [CT_W-1:0]   w_ctEff;
   logic              w_trip;

   // Multi-pulse bursts keep at least one low cycle per period.
   always_comb begin
      w_ctEff = ctIn;
      if (npIn > NP_W'(1) && CNT_W'(ctIn) >= CNT_W'(perIn))
         w_ctEff = CT_W'(perIn - PER_W'(1));
   end

   assign w_trip = r_tx && (r_onCnt == ON_W'(MAX_ON - 1));

   always_comb begin
      w_stateNxt = r_state;
      w_phaseNxt = r_phase;
      w_pdNxt    = r_pd;
      w_ctNxt    = r_ct;
      w_leftNxt  = r_left;
      w_txNxt    = r_tx;
      if (abort) begin
         w_stateNxt = CH_IDLE;
         w_txNxt    = 1'b0;
      end else if (latch) begin
         w_pdNxt    = pdIn;
         w_ctNxt    = w_ctEff;
         w_leftNxt  = npIn;
         w_phaseNxt = '0;
         if (w_ctEff == '0 || npIn == '0) begin
            w_stateNxt = CH_DONE;
            w_txNxt    = 1'b0;
         end else if (pdIn == '0) begin
            w_stateNxt = CH_ON;
            w_txNxt    = 1'b1;
         end else begin
            w_stateNxt = CH_WAIT_PD;
            w_txNxt    = 1'b0;
         end
      end else begin
         case (r_state)
            CH_WAIT_PD: begin
               if (r_phase == CNT_W'(r_pd) - CNT_W'(1)) begin
                  w_stateNxt = CH_ON;
                  w_phaseNxt = '0;
                  w_txNxt    = 1'b1;
               end else begin
                  w_phaseNxt = r_phase + CNT_W'(1);
               end
            end
            CH_ON: begin
               if (w_trip) begin
                  w_stateNxt = CH_DONE;
                  w_txNxt    = 1'b0;
               end else if (r_phase == CNT_W'(r_ct) - CNT_W'(1)) begin
                  w_txNxt = 1'b0;
                  if (r_left > NP_W'(1)) begin
                     w_stateNxt = CH_OFF;
                     w_leftNxt  = r_left - NP_W'(1);
                     w_phaseNxt = r_phase + CNT_W'(1);
                  end else begin
                     w_stateNxt = CH_DONE;
                  end
               end else begin
                  w_phaseNxt = r_phase + CNT_W'(1);
               end
            end
            CH_OFF: begin
               if (r_phase == CNT_W'(per) - CNT_W'(1)) begin
                  w_stateNxt = CH_ON;
                  w_phaseNxt = '0;
                  w_txNxt    = 1'b1;
               end else begin
                  w_phaseNxt = r_phase + CNT_W'(1);
               end
            end
            CH_DONE: begin
               if (!busy) w_stateNxt = CH_IDLE;
            end
            default: begin
               w_stateNxt = CH_IDLE;
               w_txNxt    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CH_IDLE;
         r_phase <= '0;
         r_pd    <= '0;
         r_ct    <= '0;
         r_left  <= '0;
         r_tx    <= 1'b0;
         r_err   <= 1'b0;
         r_onCnt <= '0;
      end else begin
         r_state <= w_stateNxt;
         r_phase <= w_phaseNxt;
         r_pd    <= w_pdNxt;
         r_ct    <= w_ctNxt;
         r_left  <= w_leftNxt;
         r_tx    <= w_txNxt;
         r_onCnt <= r_tx ? r_onCnt + ON_W'(1) : '0;
         // Clear wins over a concurrent trip.
         if (clrErr)
            r_err <= 1'b0;
         else if (w_trip)
            r_err <= 1'b1;
      end
   end

   assign txOut    = r_tx;
   assign errOut   = r_err;
   assign doneNext = (w_stateNxt == CH_DONE);

endmodule
`default_nettype wire

// File: rtl/tx_burst_array.sv
`default_nettype none
// ============================================================================
// Module   : tx_burst_array
// Brief    : N-channel transmit burst generator with arm/abort and done/busy.
// Revision : 1.0
// ============================================================================
module tx_burst_array
   import tx_burst_pkg::*;
#(
   parameter int N_CH   = 8,
   parameter int PD_W   = 16,
   parameter int CT_W   = 9,
   parameter int NP_W   = 8,
   parameter int PER_W  = 16,
   parameter int MAX_ON = 512
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           cmd,
   input  logic                 fire_switch,
   input  logic [N_CH*PD_W-1:0] phase_delay,
   input  logic [N_CH*PD_W-1:0] alt_phase_delay,
   input  logic [N_CH*CT_W-1:0] charge_time,
   input  logic [NP_W-1:0]      n_pulses,
   input  logic [PER_W-1:0]     period,
   output logic [N_CH-1:0]      tx_out,
   output logic                 busy,
   output logic                 done,
   output logic [N_CH-1:0]      error
);

   logic             r_armed, r_busy, r_done;
   logic [PER_W-1:0] r_per;
   logic             w_fire, w_clr, w_abort, w_latch, w_allDone;
   logic [NP_W-1:0]  w_npEff;
   logic [N_CH-1:0]  w_chDoneNext;

   assign w_fire    = (cmd == CMD_FIRE);
   assign w_clr     = cmd[1];               // CLEAR and the 11 code
   assign w_abort   = r_busy && !w_fire;
   assign w_latch   = w_fire && !r_armed && !r_busy;
   assign w_allDone = &w_chDoneNext;
   assign w_npEff   = (period == '0 && n_pulses > NP_W'(1)) ? NP_W'(1) : n_pulses;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic [PD_W-1:0] w_pdSel;
         assign w_pdSel = fire_switch ? phase_delay[i*PD_W +: PD_W]
                                      : alt_phase_delay[i*PD_W +: PD_W];
         tx_burst_channel #(
            .PD_W   (PD_W),
            .CT_W   (CT_W),
            .NP_W   (NP_W),
            .PER_W  (PER_W),
            .MAX_ON (MAX_ON)
         ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .latch    (w_latch),
            .abort    (w_abort),
            .clrErr   (w_clr),
            .busy     (r_busy),
            .pdIn     (w_pdSel),
            .ctIn     (charge_time[i*CT_W +: CT_W]),
            .npIn     (w_npEff),
            .perIn    (period),
            .per      (r_per),
            .txOut    (tx_out[i]),
            .errOut   (error[i]),
            .doneNext (w_chDoneNext[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_per   <= '0;
      end else begin
         r_done <= 1'b0;
         if (!w_fire)
            r_armed <= 1'b0;
         else if (w_latch)
            r_armed <= 1'b1;
         if (w_abort) begin
            r_busy <= 1'b0;
         end else if (w_latch) begin
            r_per  <= period;
            // A burst with nothing to emit completes at the latch edge.
            r_busy <= !w_allDone;
            r_done <= w_allDone;
         end else if (r_busy && w_allDone) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_burst_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_burst_array
// Brief    : Directed self-checking bench for tx_burst_array.
// Revision : 1.0
// ============================================================================
module tb_tx_burst_array;

   localparam int N_CH   = 8;
   localparam int PD_W   = 16;
   localparam int CT_W   = 9;
   localparam int NP_W   = 8;
   localparam int PER_W  = 16;
   localparam int MAX_ON = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [1:0]           cmd;
   logic                 fire_switch;
   logic [N_CH*PD_W-1:0] phase_delay;
   logic [N_CH*PD_W-1:0] alt_phase_delay;
   logic [N_CH*CT_W-1:0] charge_time;
   logic [NP_W-1:0]      n_pulses;
   logic [PER_W-1:0]     period;
   logic [N_CH-1:0]      tx_out;
   logic                 busy;
   logic                 done;
   logic [N_CH-1:0]      error;

   int checks = 0;
   int errors = 0;

   tx_burst_array #(
      .N_CH(N_CH), .PD_W(PD_W), .CT_W(CT_W), .NP_W(NP_W),
      .PER_W(PER_W), .MAX_ON(MAX_ON)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd             (cmd),
      .fire_switch     (fire_switch),
      .phase_delay     (phase_delay),
      .alt_phase_delay (alt_phase_delay),
      .charge_time     (charge_time),
      .n_pulses        (n_pulses),
      .period          (period),
      .tx_out          (tx_out),
      .busy            (busy),
      .done            (done),
      .error           (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearCfg();
      phase_delay     = '0;
      alt_phase_delay = '0;
      charge_time     = '0;
   endtask

   task automatic setCh(input int ch, input int pd, input int alt, input int ct);
      phase_delay[ch*PD_W +: PD_W]     = PD_W'(pd);
      alt_phase_delay[ch*PD_W +: PD_W] = PD_W'(alt);
      charge_time[ch*CT_W +: CT_W]     = CT_W'(ct);
   endtask

   initial begin
      logic sawBad;
      rst_n = 1'b0; cmd = 2'b00; fire_switch = 1'b1;
      n_pulses = '0; period = '0;
      clearCfg();
      tick(); tick();
      chk("rst_tx",    32'(tx_out), 32'(0));
      chk("rst_busy",  32'(busy),   32'(0));
      chk("rst_done",  32'(done),   32'(0));
      chk("rst_error", 32'(error),  32'(0));
      rst_n = 1'b1;
      tick();

      // Single pulse: ch0 pd0 ct4, ch1 pd3 ct2
      setCh(0, 0, 0, 4); setCh(1, 3, 0, 2);
      n_pulses = 8'd1; period = 16'd10; fire_switch = 1'b1;
      cmd = 2'b01;
      tick();
      for (int t = 0; t <= 6; t++) begin
         chk($sformatf("single_tx0_t%0d", t),  32'(tx_out[0]), 32'(t < 4));
         chk($sformatf("single_tx1_t%0d", t),  32'(tx_out[1]), 32'(t >= 3 && t < 5));
         chk($sformatf("single_done_t%0d", t), 32'(done),      32'(t == 5));
         chk($sformatf("single_busy_t%0d", t), 32'(busy),      32'(t < 5));
         tick();
      end
      sawBad = 1'b0;
      for (int t = 0; t < 6; t++) begin
         if (busy || tx_out != '0) sawBad = 1'b1;
         tick();
      end
      chk("hold_fire_no_refire", 32'(sawBad), 32'(0));
      cmd = 2'b00; tick(); tick();

      // Burst with width clamp: pulses at t 2..6, 8..12, 14..18
      clearCfg();
      setCh(0, 2, 0, 10);
      n_pulses = 8'd3; period = 16'd6;
      cmd = 2'b01;
      tick();
      for (int t = 0; t <= 21; t++) begin
         chk($sformatf("clamp_tx0_t%0d", t), 32'(tx_out[0]),
             32'((t >= 2 && t <= 6) || (t >= 8 && t <= 12) || (t >= 14 && t <= 18)));
         chk($sformatf("clamp_done_t%0d", t), 32'(done), 32'(t == 19));
         tick();
      end
      cmd = 2'b00; tick(); tick();

      // Alternate delay set: first rise at t7
      clearCfg();
      setCh(0, 1, 7, 3);
      n_pulses = 8'd1; period = 16'd10; fire_switch = 1'b0;
      cmd = 2'b01;
      tick();
      for (int t = 0; t <= 10; t++) begin
         chk($sformatf("alt_tx0_t%0d", t),  32'(tx_out[0]), 32'(t >= 7 && t <= 9));
         chk($sformatf("alt_done_t%0d", t), 32'(done),      32'(t == 10));
         tick();
      end
      tick(); tick();
      chk("alt_hold_busy", 32'(busy), 32'(0));
      cmd = 2'b00; tick();
      cmd = 2'b01; tick();
      chk("refire_busy", 32'(busy), 32'(1));
      for (int t = 1; t <= 7; t++) tick();
      chk("refire_tx0_t7", 32'(tx_out[0]), 32'(1));
      for (int t = 8; t <= 11; t++) tick();
      cmd = 2'b00; tick(); tick();

      // Abort mid-pulse at t25
      clearCfg();
      setCh(0, 0, 0, 10);
      n_pulses = 8'd4; period = 16'd20; fire_switch = 1'b1;
      cmd = 2'b01;
      tick();
      for (int t = 1; t <= 25; t++) tick();
      chk("abort_tx0_t25",  32'(tx_out[0]), 32'(1));
      chk("abort_busy_t25", 32'(busy),      32'(1));
      cmd = 2'b00;
      tick();
      chk("abort_tx_t26",   32'(tx_out), 32'(0));
      chk("abort_busy_t26", 32'(busy),   32'(0));
      sawBad = 1'b0;
      for (int t = 0; t < 60; t++) begin
         if (done || tx_out != '0) sawBad = 1'b1;
         tick();
      end
      chk("abort_no_done", 32'(sawBad), 32'(0));

      // Safety trip on ch2 after 16 high cycles
      clearCfg();
      setCh(0, 0, 0, 3); setCh(2, 1, 0, 300);
      n_pulses = 8'd1; period = 16'd10;
      cmd = 2'b01;
      tick();
      for (int t = 0; t <= 19; t++) begin
         chk($sformatf("trip_tx2_t%0d", t),  32'(tx_out[2]), 32'(t >= 1 && t <= 16));
         chk($sformatf("trip_err_t%0d", t),  32'(error),     32'(t >= 17 ? 8'h04 : 8'h00));
         chk($sformatf("trip_done_t%0d", t), 32'(done),      32'(t == 17));
         tick();
      end
      cmd = 2'b00; tick(); tick();
      chk("idle_keeps_error", 32'(error), 32'(8'h04));
      cmd = 2'b10; tick();
      chk("clear_error", 32'(error), 32'(0));
      cmd = 2'b00; tick();

      // Asynchronous reset mid-burst, then immediate refire
      clearCfg();
      setCh(0, 0, 0, 8);
      cmd = 2'b01;
      tick(); tick();
      chk("pre_rst_tx0", 32'(tx_out[0]), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx",   32'(tx_out), 32'(0));
      chk("async_rst_busy", 32'(busy),   32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_tx0",  32'(tx_out[0]), 32'(1));
      chk("post_rst_busy", 32'(busy),      32'(1));
      cmd = 2'b00; tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
